// File: rtl/lpc_host_master.sv
// LPC I/O-cycle initiator: converts single-byte read/write requests into
// LFRAME#/LAD[3:0] cycles, handling SYNC waits, error SYNC and timeout aborts.
module lpc_host_master #(
  parameter int unsigned SYNC_TIMEOUT  = 32,
  parameter int unsigned LONG_WAIT_MAX = 1023,
  parameter int unsigned ABORT_CYCLES  = 4
) (
  input  logic        lclk,
  input  logic        lreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        lframe_n,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  input  logic [3:0]  lad_in
);

  localparam int unsigned WAIT_MAX = (SYNC_TIMEOUT > LONG_WAIT_MAX) ? SYNC_TIMEOUT : LONG_WAIT_MAX;
  localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);
  localparam int unsigned ABT_W    = $clog2(ABORT_CYCLES + 1);

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_CYCTYP, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_WDATA0, S_WDATA1, S_HTAR0, S_HTAR1, S_SYNC, S_RDATA0, S_RDATA1,
    S_PTAR0, S_PTAR1, S_DONE, S_ABORT, S_RECOVER
  } state_t;

  typedef enum logic [1:0] {CLS_NONE, CLS_SHORT, CLS_LONG} cls_t;

  state_t             r_state, w_next;
  cls_t               r_cls, w_cls_nxt;
  logic [CNT_W-1:0]   r_wait_cnt, w_cnt_nxt;
  logic [ABT_W-1:0]   r_abort_cnt, w_abt_nxt;
  logic               r_err, w_err_nxt;
  logic [7:0]         r_rdata, w_rdata_nxt;
  logic [15:0]        r_addr;
  logic [7:0]         r_wdata;
  logic               r_write;
  logic               w_accept;

  logic               r_lframe_n, w_lframe_n;
  logic [3:0]         r_lad_out, w_lad_out;
  logic               r_lad_oe, w_lad_oe;
  logic               r_req_ready, w_req_ready;
  logic               r_rsp_valid, w_rsp_valid;
  logic [7:0]         r_rsp_rdata, w_rsp_rdata;
  logic               r_rsp_err, w_rsp_err;
  logic               r_rsp_timeout, w_rsp_timeout;

  assign w_accept = (r_state == S_IDLE) && req_valid;

  // Next-state logic plus the registered output values for the state being entered
  always_comb begin
    w_next      = r_state;
    w_cls_nxt   = r_cls;
    w_cnt_nxt   = r_wait_cnt;
    w_abt_nxt   = r_abort_cnt;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_next    = S_START;
          w_err_nxt = 1'b0;
        end
      end
      S_START:  w_next = S_CYCTYP;
      S_CYCTYP: w_next = S_ADDR0;
      S_ADDR0:  w_next = S_ADDR1;
      S_ADDR1:  w_next = S_ADDR2;
      S_ADDR2:  w_next = S_ADDR3;
      S_ADDR3:  w_next = r_write ? S_WDATA0 : S_HTAR0;
      S_WDATA0: w_next = S_WDATA1;
      S_WDATA1: w_next = S_HTAR0;
      S_HTAR0:  w_next = S_HTAR1;
      S_HTAR1: begin
        w_next    = S_SYNC;
        w_cls_nxt = CLS_NONE;
        w_cnt_nxt = '0;
      end
      S_SYNC: begin
        case (lad_in)
          4'b0000: w_next = r_write ? S_PTAR0 : S_RDATA0;
          4'b1010: begin
            w_next    = r_write ? S_PTAR0 : S_RDATA0;
            w_err_nxt = 1'b1;
          end
          4'b0101, 4'b1111: begin
            w_cls_nxt = CLS_SHORT;
            w_cnt_nxt = (r_cls == CLS_SHORT) ? CNT_W'(r_wait_cnt + CNT_W'(1)) : CNT_W'(1);
            if (w_cnt_nxt == CNT_W'(SYNC_TIMEOUT)) begin
              w_next    = S_ABORT;
              w_abt_nxt = '0;
            end
          end
          4'b0110: begin
            w_cls_nxt = CLS_LONG;
            w_cnt_nxt = (r_cls == CLS_LONG) ? CNT_W'(r_wait_cnt + CNT_W'(1)) : CNT_W'(1);
            if (w_cnt_nxt == CNT_W'(LONG_WAIT_MAX)) begin
              w_next    = S_ABORT;
              w_abt_nxt = '0;
            end
          end
          default: begin
            w_next    = S_ABORT;
            w_abt_nxt = '0;
          end
        endcase
      end
      S_RDATA0: begin
        w_next           = S_RDATA1;
        w_rdata_nxt[3:0] = lad_in;
      end
      S_RDATA1: begin
        w_next           = S_PTAR0;
        w_rdata_nxt[7:4] = lad_in;
      end
      S_PTAR0:  w_next = S_PTAR1;
      S_PTAR1:  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      S_ABORT: begin
        if (r_abort_cnt == ABT_W'(ABORT_CYCLES - 1)) begin
          w_next = S_RECOVER;
        end else begin
          w_abt_nxt = ABT_W'(r_abort_cnt + ABT_W'(1));
        end
      end
      S_RECOVER: w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase

    w_lframe_n    = 1'b1;
    w_lad_out     = 4'b1111;
    w_lad_oe      = 1'b0;
    w_req_ready   = (w_next == S_IDLE);
    w_rsp_valid   = (w_next == S_DONE);
    w_rsp_err     = 1'b0;
    w_rsp_timeout = 1'b0;
    w_rsp_rdata   = r_rsp_rdata;

    case (w_next)
      S_START:  begin w_lframe_n = 1'b0; w_lad_oe = 1'b1; w_lad_out = 4'b0000; end
      S_CYCTYP: begin w_lad_oe = 1'b1; w_lad_out = r_write ? 4'b0010 : 4'b0000; end
      S_ADDR0:  begin w_lad_oe = 1'b1; w_lad_out = r_addr[15:12]; end
      S_ADDR1:  begin w_lad_oe = 1'b1; w_lad_out = r_addr[11:8]; end
      S_ADDR2:  begin w_lad_oe = 1'b1; w_lad_out = r_addr[7:4]; end
      S_ADDR3:  begin w_lad_oe = 1'b1; w_lad_out = r_addr[3:0]; end
      S_WDATA0: begin w_lad_oe = 1'b1; w_lad_out = r_wdata[3:0]; end
      S_WDATA1: begin w_lad_oe = 1'b1; w_lad_out = r_wdata[7:4]; end
      S_HTAR0:  begin w_lad_oe = 1'b1; w_lad_out = 4'b1111; end
      S_ABORT:  begin w_lframe_n = 1'b0; w_lad_oe = 1'b1; w_lad_out = 4'b1111; end
      S_DONE: begin
        if (r_state == S_RECOVER) begin
          w_rsp_err     = 1'b1;
          w_rsp_timeout = 1'b1;
          w_rsp_rdata   = 8'hFF;
        end else begin
          w_rsp_err = r_err;
          if (!r_write) w_rsp_rdata = r_rdata;
        end
      end
      default: ;
    endcase
  end

  // State, bookkeeping and registered outputs
  always_ff @(posedge lclk or posedge lreset) begin
    if (lreset) begin
      r_state       <= S_IDLE;
      r_cls         <= CLS_NONE;
      r_wait_cnt    <= '0;
      r_abort_cnt   <= '0;
      r_err         <= 1'b0;
      r_rdata       <= 8'h00;
      r_lframe_n    <= 1'b1;
      r_lad_out     <= 4'b1111;
      r_lad_oe      <= 1'b0;
      r_req_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= 8'h00;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cls         <= w_cls_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_abort_cnt   <= w_abt_nxt;
      r_err         <= w_err_nxt;
      r_rdata       <= w_rdata_nxt;
      r_lframe_n    <= w_lframe_n;
      r_lad_out     <= w_lad_out;
      r_lad_oe      <= w_lad_oe;
      r_req_ready   <= w_req_ready;
      r_rsp_valid   <= w_rsp_valid;
      r_rsp_rdata   <= w_rsp_rdata;
      r_rsp_err     <= w_rsp_err;
      r_rsp_timeout <= w_rsp_timeout;
    end
  end

  // Request capture on acceptance
  always_ff @(posedge lclk or posedge lreset) begin
    if (lreset) begin
      r_addr  <= 16'h0000;
      r_wdata <= 8'h00;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_write <= req_write;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;
  assign lframe_n    = r_lframe_n;
  assign lad_out     = r_lad_out;
  assign lad_oe      = r_lad_oe;

endmodule

// File: tb/tb_lpc_host_master.sv
// Directed bench for lpc_host_master: scripted peripheral SYNC/data on lad_in,
// per-cycle bus trace and a response scoreboard.
module tb_lpc_host_master;

  logic        lclk = 1'b0;
  logic        lreset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        lframe_n;
  logic [3:0]  lad_out;
  logic        lad_oe;
  logic [3:0]  lad_in = 4'hF;

  lpc_host_master dut (
    .lclk(lclk), .lreset(lreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .lframe_n(lframe_n), .lad_out(lad_out), .lad_oe(lad_oe), .lad_in(lad_in)
  );

  always #5 lclk = ~lclk;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         lat;
  } exp_t;

  exp_t        sb[$];
  logic [3:0]  script[$];
  logic        tr_fr[0:2047];
  logic [3:0]  tr_lad[0:2047];
  logic        tr_oe[0:2047];
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  last_rdata = 8'h00;
  int          lat;
  int          acc_wait;
  logic        gap_fr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of the response the next request must produce
  task automatic expect_rsp(input bit wr, input logic [7:0] rd, input bit err, input bit to,
                            input int l);
    exp_t e;
    e.rdata = to ? 8'hFF : (wr ? last_rdata : rd);
    e.err   = err | to;
    e.to    = to;
    e.lat   = l;
    last_rdata = e.rdata;
    sb.push_back(e);
  endtask

  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [7:0] wd, input bit hold);
    int   sync_cyc;
    int   idx;
    int   cyc;
    bit   seen;
    exp_t e;
    sync_cyc  = wr ? 11 : 9;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    acc_wait  = 0;
    while (!req_ready && acc_wait < 100) begin
      @(negedge lclk);
      acc_wait++;
    end
    gap_fr = lframe_n;
    chk("accept", req_ready, 1);
    @(negedge lclk);
    if (!hold) req_valid = 1'b0;
    idx  = 0;
    seen = 0;
    lat  = 0;
    cyc  = 1;
    while (!seen && cyc < 2000) begin
      tr_fr[cyc]  = lframe_n;
      tr_lad[cyc] = lad_out;
      tr_oe[cyc]  = lad_oe;
      if (rsp_valid) begin
        seen = 1;
        lat  = cyc;
      end else begin
        if (cyc >= sync_cyc && idx < script.size()) begin
          lad_in = script[idx];
          idx++;
        end else begin
          lad_in = 4'hF;
        end
        @(negedge lclk);
        cyc++;
      end
    end
    lad_in = 4'hF;
    chk("rsp_seen", seen, 1);
    if (seen && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_timeout", rsp_timeout, e.to);
      chk("latency", lat, e.lat);
    end
    script.delete();
  endtask

  initial begin
    logic [3:0] wr_seq[0:8];
    int         lows;
    bit         stray;
    wr_seq = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h8, 4'h0, 4'hC, 4'h3, 4'hF};

    // Reset values
    repeat (2) @(negedge lclk);
    chk("rst_lframe_n", lframe_n, 1);
    chk("rst_lad_out", lad_out, 4'hF);
    chk("rst_lad_oe", lad_oe, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    lreset = 1'b0;
    @(negedge lclk);

    // Write 0x3C to 0x0080, immediate ready SYNC
    script = '{4'h0};
    expect_rsp(1, 8'h00, 0, 0, 14);
    do_txn(1, 16'h0080, 8'h3C, 0);
    lows = 0;
    for (int i = 1; i <= lat; i++) if (tr_fr[i] == 1'b0) lows++;
    chk("w1_lframe_low_cycles", lows, 1);
    for (int i = 1; i <= 9; i++) begin
      chk($sformatf("w1_lad_c%0d", i), tr_lad[i], wr_seq[i-1]);
      chk($sformatf("w1_oe_c%0d", i), tr_oe[i], 1);
    end
    for (int i = 10; i <= 14; i++) chk($sformatf("w1_float_c%0d", i), tr_oe[i], 0);
    @(negedge lclk);
    chk("rsp_valid_one_cycle", rsp_valid, 0);

    // Read 0x03FD with three short waits, data 0x60
    script = '{4'h5, 4'h5, 4'h5, 4'h0, 4'h0, 4'h6};
    expect_rsp(0, 8'h60, 0, 0, 17);
    do_txn(0, 16'h03FD, 8'h00, 0);
    chk("r1_cyctyp", tr_lad[2], 4'h0);
    chk("r1_addr0", tr_lad[3], 4'h0);
    chk("r1_addr1", tr_lad[4], 4'h3);
    chk("r1_addr2", tr_lad[5], 4'hF);
    chk("r1_addr3", tr_lad[6], 4'hD);
    for (int i = 8; i <= 17; i++) chk($sformatf("r1_float_c%0d", i), tr_oe[i], 0);

    // Read 0x03F8 with no responder: timeout abort
    expect_rsp(0, 8'h00, 1, 1, 46);
    do_txn(0, 16'h03F8, 8'h00, 0);
    chk("to_sync_float", tr_oe[40], 0);
    for (int i = 41; i <= 44; i++) begin
      chk($sformatf("to_abort_fr_c%0d", i), tr_fr[i], 0);
      chk($sformatf("to_abort_lad_c%0d", i), tr_lad[i], 4'hF);
      chk($sformatf("to_abort_oe_c%0d", i), tr_oe[i], 1);
    end
    chk("to_recover_fr", tr_fr[45], 1);
    chk("to_recover_oe", tr_oe[45], 0);

    // Write 0x03F9 with error SYNC; junk on lad_in during PTAR must be ignored
    script = '{4'hA, 4'h3, 4'h3};
    expect_rsp(1, 8'h00, 1, 0, 14);
    do_txn(1, 16'h03F9, 8'hA5, 0);
    chk("err_ptar0_oe", tr_oe[12], 0);
    chk("err_ptar1_oe", tr_oe[13], 0);

    // Class change from short to long wait restarts the count: no abort
    script = {};
    for (int i = 0; i < 31; i++) script.push_back(4'hF);
    script.push_back(4'h6);
    script.push_back(4'h0);
    script.push_back(4'h2);
    script.push_back(4'hC);
    expect_rsp(0, 8'hC2, 0, 0, 46);
    do_txn(0, 16'h0080, 8'h00, 0);

    // Unknown SYNC code aborts at once
    script = '{4'h3};
    expect_rsp(0, 8'h00, 1, 1, 15);
    do_txn(0, 16'h03FB, 8'h00, 0);

    // Back-to-back requests with req_valid held
    script = '{4'h0};
    expect_rsp(1, 8'h00, 0, 0, 14);
    do_txn(1, 16'h0080, 8'h11, 1);
    chk("b2b_first_end_fr", tr_fr[lat], 1);
    script = '{4'h0, 4'h5, 4'hA};
    expect_rsp(0, 8'hA5, 0, 0, 14);
    do_txn(0, 16'h03FA, 8'h00, 0);
    chk("b2b_accept_wait", acc_wait, 1);
    chk("b2b_gap_lframe", gap_fr, 1);
    chk("b2b_second_start", tr_fr[1], 0);

    // Reset during ADDR nibble 2
    @(negedge lclk);
    req_write = 1'b0;
    req_addr  = 16'h03FC;
    req_valid = 1'b1;
    @(negedge lclk);
    req_valid = 1'b0;
    repeat (3) @(negedge lclk);
    chk("rst_mid_addr_nibble", lad_out, 4'h3);
    chk("rst_mid_addr_oe", lad_oe, 1);
    #2 lreset = 1'b1;
    #1;
    chk("rst_mid_lframe_n", lframe_n, 1);
    chk("rst_mid_lad_oe", lad_oe, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    repeat (2) @(negedge lclk);
    lreset = 1'b0;
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge lclk);
      if (rsp_valid) stray = 1;
    end
    chk("rst_mid_no_rsp", stray, 0);
    chk("rst_mid_ready_after", req_ready, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
